// File: rtl/alu_iterative.sv
// Registered ALU with valid/ready handshakes; single-cycle base ops plus
// iterative shift-add multiply and restoring unsigned divide.
module alu_iterative #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_operation,
    input  logic [WIDTH-1:0] i_operand_A,
    input  logic [WIDTH-1:0] i_operand_B,
    input  logic             i_kill,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;
    localparam logic [3:0] OP_MULHU = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [SHW-1:0]       cnt_q;
    logic [WIDTH-1:0]     result_q;

    logic                 accept;
    logic                 is_iter;
    logic                 last_step;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     base_res;
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quo_next;
    logic [WIDTH-1:0]     iter_res;

    assign accept    = i_valid & o_ready & ~i_kill;
    assign is_iter   = (i_operation >= OP_MUL) && (i_operation <= 4'd14);
    assign last_step = (cnt_q == SHW'(WIDTH - 1));
    assign shamt     = i_operand_B[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (i_operation)
            OP_ADD:  base_res = i_operand_A + i_operand_B;
            OP_SUB:  base_res = i_operand_A - i_operand_B;
            OP_OR:   base_res = i_operand_A | i_operand_B;
            OP_AND:  base_res = i_operand_A & i_operand_B;
            OP_XOR:  base_res = i_operand_A ^ i_operand_B;
            OP_NOT:  base_res = ~i_operand_A;
            OP_SLTU: base_res = {{(WIDTH-1){1'b0}},
                                 (i_operand_A < i_operand_B)};
            OP_SLT:  base_res = {{(WIDTH-1){1'b0}},
                                 ($signed(i_operand_A) < $signed(i_operand_B))};
            OP_SLL:  base_res = i_operand_A << shamt;
            OP_SRL:  base_res = i_operand_A >> shamt;
            OP_SRA:  base_res = $unsigned($signed(i_operand_A) >>> shamt);
            default: base_res = '0;
        endcase
    end

    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, a_q} : '0);
        prod_next = {mul_sum, prod_q[WIDTH-1:1]};
    end

    // Restoring divide: dividend bits shift out of quo_q into the remainder.
    always_comb begin
        div_shift = {rem_q, quo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, b_q});
        rem_next  = div_ge ? WIDTH'(div_shift - {1'b0, b_q})
                           : div_shift[WIDTH-1:0];
        quo_next  = {quo_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        iter_res = '0;
        case (op_q)
            OP_MUL:   iter_res = prod_next[WIDTH-1:0];
            OP_MULHU: iter_res = prod_next[2*WIDTH-1:WIDTH];
            OP_DIVU:  iter_res = quo_next;
            default:  iter_res = rem_next;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_kill) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = is_iter ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    if (last_step) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (accept) begin
                        state_d = is_iter ? BUSY : DONE;
                    end else if (i_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        o_valid = (state_q == DONE);
        o_ready = (state_q == IDLE) | ((state_q == DONE) & i_ready);
        o_result = result_q;
        o_zero   = (result_q == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (i_kill) begin
            cnt_q <= '0;
        end else if (accept) begin
            op_q <= i_operation;
            if (is_iter) begin
                a_q    <= i_operand_A;
                b_q    <= i_operand_B;
                prod_q <= {{WIDTH{1'b0}}, i_operand_B};
                rem_q  <= '0;
                quo_q  <= i_operand_A;
                cnt_q  <= '0;
            end else begin
                result_q <= base_res;
            end
        end else if (state_q == BUSY) begin
            prod_q <= prod_next;
            rem_q  <= rem_next;
            quo_q  <= quo_next;
            cnt_q  <= cnt_q + 1'b1;
            if (last_step) begin
                result_q <= iter_res;
            end
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative: base ops, iterative latency,
// divide-by-zero, DONE hold / back-to-back, kill and async reset.
module tb_alu_iterative;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_operation;
    logic [31:0] i_operand_A;
    logic [31:0] i_operand_B;
    logic        i_kill;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;

    int total;
    int passed;
    int failed;

    alu_iterative #(.WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_operation (i_operation),
        .i_operand_A (i_operand_A),
        .i_operand_B (i_operand_B),
        .i_kill      (i_kill),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_zero      (o_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle op issued from IDLE; returns to IDLE afterwards.
    task automatic run1(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        i_valid = 1'b1;
        i_operation = op;
        i_operand_A = a;
        i_operand_B = b;
        step();
        i_valid = 1'b0;
        i_operand_A = 32'hDEAD_BEEF;
        i_operand_B = 32'h1234_5678;
        chk({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
        chk(tag, o_result, exp);
        step();
    endtask

    // Iterative op: checks the cycle on which o_valid rises and the result.
    task automatic runi(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        int cyc;
        i_valid = 1'b1;
        i_operation = op;
        i_operand_A = a;
        i_operand_B = b;
        step();
        i_valid = 1'b0;
        i_operand_A = 32'h0;
        i_operand_B = 32'h0;
        cyc = 1;
        while (!o_valid && cyc < 100) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 32'd33);
        chk(tag, o_result, exp);
        step();
    endtask

    initial begin
        total = 0;
        passed = 0;
        failed = 0;
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_operation = 4'd0;
        i_operand_A = 32'd0;
        i_operand_B = 32'd0;
        i_kill = 1'b0;
        i_ready = 1'b1;
        #12;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_zero", {31'b0, o_zero}, 32'd1);
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        #10;
        rst_n = 1'b1;
        step();

        i_valid = 1'b1;
        i_operation = 4'd0;
        i_operand_A = 32'hFFFF_FFFF;
        i_operand_B = 32'd1;
        step();
        i_valid = 1'b0;
        chk("add_wrap_valid", {31'b0, o_valid}, 32'd1);
        chk("add_wrap", o_result, 32'd0);
        chk("add_wrap_zero", {31'b0, o_zero}, 32'd1);
        step();
        chk("idle_after_done", {31'b0, o_valid}, 32'd0);

        run1("slt", 4'd7, 32'hFFFF_FFFE, 32'd1, 32'd1);
        run1("sltu", 4'd6, 32'hFFFF_FFFE, 32'd1, 32'd0);
        run1("sra", 4'd10, 32'h8000_0000, 32'h21, 32'hC000_0000);
        run1("srl", 4'd9, 32'h8000_0000, 32'h21, 32'h4000_0000);
        run1("sll0", 4'd8, 32'h1234_5678, 32'h20, 32'h1234_5678);
        run1("sub", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF);
        run1("xor", 4'd4, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000);
        run1("not", 4'd5, 32'h0000_FFFF, 32'h0, 32'hFFFF_0000);
        run1("rsvd", 4'd15, 32'h5, 32'h7, 32'd0);
        chk("rsvd_zero", {31'b0, o_zero}, 32'd1);

        runi("mulhu", 4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runi("mul", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        runi("mul_small", 4'd11, 32'd1234, 32'd5678, 32'd7006652);
        runi("divu_b0", 4'd13, 32'd100, 32'd0, 32'hFFFF_FFFF);
        runi("remu_b0", 4'd14, 32'd100, 32'd0, 32'd100);
        runi("divu", 4'd13, 32'd100, 32'd7, 32'd14);
        runi("remu", 4'd14, 32'd100, 32'd7, 32'd2);

        i_ready = 1'b0;
        i_valid = 1'b1;
        i_operation = 4'd0;
        i_operand_A = 32'd5;
        i_operand_B = 32'd6;
        step();
        i_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_result", o_result, 32'd11);
            chk("hold_ready", {31'b0, o_ready}, 32'd0);
            chk("hold_valid", {31'b0, o_valid}, 32'd1);
            step();
        end
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_operand_A = 32'd7;
        i_operand_B = 32'd8;
        #1;
        chk("b2b_ready", {31'b0, o_ready}, 32'd1);
        step();
        i_valid = 1'b0;
        chk("b2b_valid", {31'b0, o_valid}, 32'd1);
        chk("b2b_result", o_result, 32'd15);
        step();
        chk("b2b_idle", {31'b0, o_valid}, 32'd0);

        i_valid = 1'b1;
        i_operation = 4'd13;
        i_operand_A = 32'd100;
        i_operand_B = 32'd7;
        step();
        i_valid = 1'b0;
        for (int i = 1; i < 10; i++) begin
            step();
        end
        i_kill = 1'b1;
        step();
        i_kill = 1'b0;
        chk("kill_valid", {31'b0, o_valid}, 32'd0);
        chk("kill_ready", {31'b0, o_ready}, 32'd1);
        chk("kill_result", o_result, 32'd15);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (o_valid) seen++;
                step();
            end
            chk("kill_no_valid", seen, 32'd0);
        end
        run1("post_kill_and", 4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        chk("nonzero_flag", {31'b0, o_zero}, 32'd0);

        i_valid = 1'b1;
        i_operation = 4'd11;
        i_operand_A = 32'd3;
        i_operand_B = 32'd5;
        step();
        i_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("amid_valid", {31'b0, o_valid}, 32'd0);
        chk("amid_result", o_result, 32'd0);
        chk("amid_zero", {31'b0, o_zero}, 32'd1);
        chk("amid_ready", {31'b0, o_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        step();
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (o_valid) seen++;
                step();
            end
            chk("rst_no_stale", seen, 32'd0);
        end
        run1("post_rst_or", 4'd2, 32'hA000_0000, 32'h0000_000A, 32'hA000_000A);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
